// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 8-slot TDM receive demultiplexer.
package tdm_pkg;
    localparam int unsigned NCH    = 8;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned ERR_W  = 8;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clr forces 0, load1 realigns to 1, inc advances with natural wrap.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load1,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot
);
    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = SLOT_W'(1);
        end else if (inc) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
endmodule

// File: rtl/tdm_demux8.sv
// 8-slot TDM receiver: aligns to frame_sync, stages samples per slot and
// publishes all channels together once a complete frame has been received.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter bit          STRICT_SYNC = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [NCH*WIDTH-1:0] ch_data,
    output logic                 frame_valid,
    output logic                 locked,
    output logic [SLOT_W-1:0]    slot,
    output logic                 sync_err,
    output logic [ERR_W-1:0]     err_cnt
);
    tdm_state_t                      state_q, state_d;
    logic [NCH-1:0][WIDTH-1:0]       staging_q, staging_d;
    logic [NCH*WIDTH-1:0]            ch_data_q, ch_data_d;
    logic                            frame_valid_q, frame_valid_d;
    logic                            sync_err_q, sync_err_d;
    logic [ERR_W-1:0]                err_cnt_q, err_cnt_d;
    logic                            slot_inc, slot_load1, slot_clr;
    logic [SLOT_W-1:0]               slot_cur;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (slot_inc),
        .load1 (slot_load1),
        .clr   (slot_clr),
        .slot  (slot_cur)
    );

    // Sample steering, alignment and error detection; idle cycles hold everything.
    always_comb begin
        state_d       = state_q;
        staging_d     = staging_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        err_cnt_d     = err_cnt_q;
        slot_inc      = 1'b0;
        slot_load1    = 1'b0;
        slot_clr      = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        staging_d[0] = din;
                        slot_load1   = 1'b1;
                        state_d      = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot_cur != '0)) begin
                        // Early sync: abandon the partial frame and realign on this sample.
                        sync_err_d   = 1'b1;
                        staging_d[0] = din;
                        slot_load1   = 1'b1;
                    end else if (STRICT_SYNC && !frame_sync && (slot_cur == '0)) begin
                        sync_err_d = 1'b1;
                        slot_clr   = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        staging_d[slot_cur] = din;
                        slot_inc            = 1'b1;
                        if (slot_cur == SLOT_W'(NCH - 1)) begin
                            ch_data_d     = {din, staging_q[NCH-2:0]};
                            frame_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (sync_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            staging_q     <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            staging_q     <= staging_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign ch_data     = ch_data_q;
    assign frame_valid = frame_valid_q;
    assign locked      = (state_q == LOCKED);
    assign slot        = slot_cur;
    assign sync_err    = sync_err_q;
    assign err_cnt     = err_cnt_q;
endmodule
